// File: rtl/conv_encoder_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional encoder.
package conv_encoder_pkg;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

endpackage

// File: rtl/conv_encoder_branch.sv
// One generator branch: parity of the taps selected by the polynomial.
module conv_branch
  import conv_encoder_pkg::*;
(
  input  logic         i_u,
  input  logic [K-2:0] i_sr,
  input  logic [K-1:0] i_g,
  output logic         o_c
);

  // Polynomial MSB taps the current bit, LSB the oldest register stage.
  assign o_c = ^(i_g & {i_u, i_sr});

endmodule

// File: rtl/conv_encoder.sv
// Framed feed-forward convolutional encoder: FRAME_LEN data bits, then K-1 zero tail bits.
module conv_encoder
  import conv_encoder_pkg::*;
#(
  parameter int           FRAME_LEN = 16,
  parameter logic [K-1:0] G0        = G0_DEFAULT,
  parameter logic [K-1:0] G1        = G1_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din_valid,
  input  logic       din,
  output logic       din_ready,
  output logic [1:0] dout,
  output logic       dout_valid,
  output logic       frame_done
);

  localparam int             CW        = $clog2(FRAME_LEN + 1);
  localparam int             TCW       = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [CW-1:0]  LAST_BIT  = CW'(FRAME_LEN);
  localparam logic [TCW-1:0] LAST_TAIL = TCW'(TAIL_LEN - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [TCW-1:0] r_tcnt;
  logic [TCW-1:0] w_tcnt_nxt;
  logic [K-2:0]   r_sr;
  logic [1:0]     r_dout;
  logic           r_dout_valid;
  logic           r_frame_done;

  logic w_tail;
  logic w_accept;
  logic w_shift;
  logic w_u;
  logic w_c0;
  logic w_c1;
  logic w_last_tail;

  assign w_tail      = (r_state == TAIL);
  assign din_ready   = !w_tail;
  assign w_accept    = din_valid && din_ready;
  assign w_shift     = w_accept || w_tail;
  assign w_u         = w_tail ? 1'b0 : din;
  assign w_last_tail = w_tail && (r_tcnt == LAST_TAIL);

  conv_branch u_branch0 (
    .i_u  (w_u),
    .i_sr (r_sr),
    .i_g  (G0),
    .o_c  (w_c0)
  );

  conv_branch u_branch1 (
    .i_u  (w_u),
    .i_sr (r_sr),
    .i_g  (G1),
    .o_c  (w_c1)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tcnt_nxt  = r_tcnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = CW'(1);
          w_state_nxt = (FRAME_LEN == 1) ? TAIL : DATA;
        end
      end
      DATA: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_cnt_nxt == LAST_BIT) begin
            w_state_nxt = TAIL;
          end
        end
      end
      TAIL: begin
        if (w_last_tail) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_tcnt_nxt  = '0;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_tcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // Tail cycles shift in zeros, so the register is back at all-zero on IDLE entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_shift) begin
        r_sr <= {w_u, r_sr[K-2:1]};
      end
      r_dout       <= w_shift ? {w_c0, w_c1} : 2'b00;
      r_dout_valid <= w_shift;
      r_frame_done <= w_last_tail;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: frame-level model for FRAME_LEN=4 plus literal symbol tables.
module tb_conv_encoder;

  localparam int         FL    = 4;
  localparam logic [2:0] TB_G0 = 3'b111;
  localparam logic [2:0] TB_G1 = 3'b101;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_din_valid, a_din, a_din_ready, a_dout_valid, a_frame_done;
  logic [1:0] a_dout;
  logic       b_din_valid, b_din, b_din_ready, b_dout_valid, b_frame_done;
  logic [1:0] b_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_encoder #(.FRAME_LEN(FL), .G0(TB_G0), .G1(TB_G1)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (a_din_valid),
    .din        (a_din),
    .din_ready  (a_din_ready),
    .dout       (a_dout),
    .dout_valid (a_dout_valid),
    .frame_done (a_frame_done)
  );

  conv_encoder #(.FRAME_LEN(1), .G0(TB_G0), .G1(TB_G1)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (b_din_valid),
    .din        (b_din),
    .din_ready  (b_din_ready),
    .dout       (b_dout),
    .dout_valid (b_dout_valid),
    .frame_done (b_frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a frame is the list of bits fed in, followed by two zeros; each symbol
  // is the generator parity over the newest three list entries.
  bit         m_hist[$];
  bit         m_in_tail;
  int         m_tail_n;
  logic [1:0] e_dout;
  logic       e_valid;
  logic       e_fd;

  function automatic logic [1:0] symbol(input bit h[$]);
    int         n;
    logic [2:0] taps;
    n    = h.size();
    taps = {h[n-1], (n >= 2) ? h[n-2] : 1'b0, (n >= 3) ? h[n-3] : 1'b0};
    return {^(TB_G0 & taps), ^(TB_G1 & taps)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hist.delete();
      m_in_tail = 1'b0;
      m_tail_n  = 0;
      e_dout    = 2'b00;
      e_valid   = 1'b0;
      e_fd      = 1'b0;
    end else begin
      e_fd = 1'b0;
      if (m_in_tail) begin
        m_hist.push_back(1'b0);
        e_dout  = symbol(m_hist);
        e_valid = 1'b1;
        m_tail_n++;
        if (m_tail_n == 2) begin
          e_fd      = 1'b1;
          m_in_tail = 1'b0;
          m_tail_n  = 0;
          m_hist.delete();
        end
      end else if (a_din_valid) begin
        m_hist.push_back(a_din);
        e_dout  = symbol(m_hist);
        e_valid = 1'b1;
        if (m_hist.size() == FL) m_in_tail = 1'b1;
      end else begin
        e_dout  = 2'b00;
        e_valid = 1'b0;
      end
    end
  end

  logic [1:0] a_log[$];
  logic [1:0] m_log[$];
  logic [1:0] b_log[$];
  bit         a_fd_log[$];
  bit         b_fd_log[$];
  int         a_ready_low;
  int         b_ready_low;

  always @(negedge clk) begin
    check("dout", 32'(a_dout), 32'(e_dout));
    check("dout_valid", 32'(a_dout_valid), 32'(e_valid));
    check("frame_done", 32'(a_frame_done), 32'(e_fd));
    check("din_ready", 32'(a_din_ready), 32'(!m_in_tail));
    if (a_dout_valid === 1'b1) begin
      a_log.push_back(a_dout);
      a_fd_log.push_back(a_frame_done);
    end
    if (e_valid) m_log.push_back(e_dout);
    if (a_din_ready === 1'b0) a_ready_low++;
    if (b_dout_valid === 1'b1) begin
      b_log.push_back(b_dout);
      b_fd_log.push_back(b_frame_done);
    end
    if (b_din_ready === 1'b0) b_ready_low++;
  end

  task automatic clear_logs();
    a_log.delete();
    m_log.delete();
    b_log.delete();
    a_fd_log.delete();
    b_fd_log.delete();
    a_ready_low = 0;
    b_ready_low = 0;
  endtask

  task automatic drive_a(input logic v, input logic d);
    @(negedge clk);
    #1;
    a_din_valid = v;
    a_din       = d;
  endtask

  task automatic drive_b(input logic v, input logic d);
    @(negedge clk);
    #1;
    b_din_valid = v;
    b_din       = d;
  endtask

  task automatic check_log(input string name, input logic [1:0] q[$], input logic [23:0] exp, input int n);
    check($sformatf("%s count", name), 32'(q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < q.size()) begin
        check($sformatf("%s sym%0d", name, i), 32'(q[i]), 32'(exp[2*(n-1-i) +: 2]));
      end
    end
  endtask

  task automatic check_fd(input string name, input bit q[$], input int n, input int per);
    check($sformatf("%s fd count", name), 32'(q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < q.size()) begin
        check($sformatf("%s fd%0d", name, i), 32'(q[i]), 32'((i % per) == per - 1));
      end
    end
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drive_a(1'b0, 1'b0);
  endtask

  initial begin
    a_din_valid = 1'b0;
    a_din       = 1'b0;
    b_din_valid = 1'b0;
    b_din       = 1'b0;
    reset       = 1'b1;
    #1 reset    = 1'b0;
    clear_logs();

    @(negedge clk);
    #1;
    check("rst a dout", 32'(a_dout), 32'd0);
    check("rst a dout_valid", 32'(a_dout_valid), 32'd0);
    check("rst a frame_done", 32'(a_frame_done), 32'd0);
    check("rst a din_ready", 32'(a_din_ready), 32'd1);
    check("rst b din_ready", 32'(b_din_ready), 32'd1);
    check("rst b dout_valid", 32'(b_dout_valid), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Impulse response.
    clear_logs();
    drive_a(1, 1); drive_a(1, 0); drive_a(1, 0); drive_a(1, 0);
    idle_a(4);
    check_log("impulse", a_log, 24'b11_10_11_00_00_00, 6);
    check_log("impulse model", m_log, 24'b11_10_11_00_00_00, 6);
    check_fd("impulse", a_fd_log, 6, 6);
    check("impulse ready low", 32'(a_ready_low), 32'd2);

    // Data pattern 1,0,1,1.
    clear_logs();
    drive_a(1, 1); drive_a(1, 0); drive_a(1, 1); drive_a(1, 1);
    idle_a(4);
    check_log("pattern", a_log, 24'b11_10_00_01_01_11, 6);
    check_log("pattern model", m_log, 24'b11_10_00_01_01_11, 6);
    check_fd("pattern", a_fd_log, 6, 6);
    check("pattern ready low", 32'(a_ready_low), 32'd2);

    // Same frame with a three-cycle stall after bit 2; din toggled but not valid.
    clear_logs();
    drive_a(1, 1); drive_a(1, 0);
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b0, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("stall%0d dout_valid", k), 32'(a_dout_valid), 32'd0);
      check($sformatf("stall%0d dout", k), 32'(a_dout), 32'd0);
    end
    drive_a(1, 1); drive_a(1, 1);
    idle_a(4);
    check_log("stall", a_log, 24'b11_10_00_01_01_11, 6);
    check("stall ready low", 32'(a_ready_low), 32'd2);

    // Reset after two accepts, then a fresh frame starting on the first edge.
    drive_a(1, 1); drive_a(1, 0);
    @(posedge clk);
    #2;
    reset       = 1'b0;
    a_din_valid = 1'b0;
    #1;
    check("midrst dout", 32'(a_dout), 32'd0);
    check("midrst dout_valid", 32'(a_dout_valid), 32'd0);
    check("midrst frame_done", 32'(a_frame_done), 32'd0);
    check("midrst din_ready", 32'(a_din_ready), 32'd1);
    @(negedge clk);
    #1;
    clear_logs();
    reset       = 1'b1;
    a_din_valid = 1'b1;
    a_din       = 1'b1;
    drive_a(1, 0); drive_a(1, 0); drive_a(1, 0);
    idle_a(4);
    check_log("midrst", a_log, 24'b11_10_11_00_00_00, 6);
    check_fd("midrst", a_fd_log, 6, 6);
    check("midrst ready low", 32'(a_ready_low), 32'd2);

    // Back-to-back frames of 1,1,1,1 with din_valid held high through the tails.
    clear_logs();
    for (int i = 0; i < 12; i++) drive_a(1'b1, 1'b1);
    idle_a(4);
    check_log("b2b", a_log, 24'b11_01_10_10_01_11_11_01_10_10_01_11, 12);
    check_log("b2b model", m_log, 24'b11_01_10_10_01_11_11_01_10_10_01_11, 12);
    check_fd("b2b", a_fd_log, 12, 6);
    check("b2b ready low", 32'(a_ready_low), 32'd4);

    // Single-bit frames on the FRAME_LEN=1 instance.
    clear_logs();
    drive_b(1, 1);
    for (int i = 0; i < 4; i++) drive_b(1'b0, 1'b0);
    check_log("len1", b_log, 24'b11_10_11, 3);
    check_fd("len1", b_fd_log, 3, 3);
    check("len1 ready low", 32'(b_ready_low), 32'd2);
    check("len1 idle ready", 32'(b_din_ready), 32'd1);
    clear_logs();
    drive_b(1, 0);
    for (int i = 0; i < 4; i++) drive_b(1'b0, 1'b0);
    check_log("len1 zero", b_log, 24'b00_00_00, 3);
    check_fd("len1 zero", b_fd_log, 3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning information bits per frame, legal range 1..255.
REQ-002 SHALL have parameter G0, default 3'b111, meaning generator polynomial for dout[1], MSB applied to the current input bit.
REQ-003 SHALL have parameter G1, default 3'b101, meaning generator polynomial for dout[0], same bit ordering as G0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port din_valid, input, 1 bit: upstream information bit is valid.
REQ-007 SHALL have port din, input, 1 bit: information bit.
REQ-008 SHALL have port din_ready, output, 1 bit: encoder accepts din this cycle.
REQ-009 SHALL have port dout, output, 2 bits: coded symbol {c0,c1} feeding the bit-error channel stage.
REQ-010 SHALL have port dout_valid, output, 1 bit: dout is valid this cycle.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last tail symbol.

Function
REQ-012 SHALL be a rate-1/2, K=3 feed-forward convolutional encoder with memory sr = {u(n-1), u(n-2)}.
REQ-013 SHALL compute c0 = XOR of (G0 AND {u,u(n-1),u(n-2)}) and c1 = XOR of (G1 AND {u,u(n-1),u(n-2)}); defaults give c0 = u^u1^u2 and c1 = u^u2.
REQ-014 SHALL define an accept as din_valid=1 AND din_ready=1 at a rising clk edge.
REQ-015 SHALL use FSM states IDLE, DATA and TAIL.
REQ-016 SHALL, in IDLE: din_ready=1 and sr=00; an accept moves the FSM to DATA with bit count=1, or to TAIL if FRAME_LEN=1.
REQ-017 SHALL, in DATA: din_ready=1; each accept increments the bit count; the accept that brings the count to FRAME_LEN moves the FSM to TAIL.
REQ-018 SHALL, in TAIL: din_ready=0; encode u=0 for exactly 2 cycles, one tail symbol per cycle, then return to IDLE with sr=00.
REQ-019 SHALL register all outputs: each accept or tail cycle produces dout and dout_valid=1 on the following cycle (latency 1).
REQ-020 SHALL shift sr <= {u, sr[1]} on every accept and on every tail cycle.
REQ-021 SHALL, on a cycle with din_valid=0 in IDLE or DATA, leave sr and count unchanged and drive dout_valid=0 and dout=00 on the next cycle.
REQ-022 SHALL drive frame_done=1 in the same cycle as the second tail symbol's dout_valid, and 0 otherwise.
REQ-023 SHALL size the bit counter as $clog2(FRAME_LEN+1) bits, with no wrap before the TAIL transition.
REQ-024 SHALL allow back-to-back frames: an accept in the IDLE cycle after TAIL starts the next frame, giving 2 cycles of din_ready=0 per frame.

Reset
REQ-025 SHALL, while reset=0, asynchronously force FSM=IDLE, count=0, sr=00, dout=00, dout_valid=0 and frame_done=0; din_ready is then 1 (combinational from IDLE).
REQ-026 SHALL, on reset assertion mid-frame, discard the partial frame and emit no tail symbols.
REQ-027 SHALL take the first accept on the first rising edge after reset deassertion.

Structure
REQ-028 SHALL place the FSM state typedef, constraint length K=3, default G0/G1 and tail length K-1 in the shared comm package.
REQ-029 SHALL isolate the generator XOR logic in one combinational sub-module, conv_branch (inputs: u, sr, G; output: coded bit), instantiated twice.

Verification
REQ-030 SHALL verify impulse response: FRAME_LEN=4, din=1,0,0,0 continuous -> dout 11,10,11,00,00,00; frame_done on the 6th symbol.
REQ-031 SHALL verify data pattern: FRAME_LEN=4, din=1,0,1,1 -> dout 11,10,00,01,01,11; din_ready=0 during the 2 TAIL cycles.
REQ-032 SHALL verify stalls: the same frame with din_valid=0 for 3 cycles after bit 2 -> identical symbol sequence, with dout_valid=0 and dout=00 during the gap.
REQ-033 SHALL verify mid-frame reset: reset=0 after 2 accepts -> all outputs 0 immediately; the next frame 1,0,0,0 yields 11,10,11,00,00,00.
REQ-034 SHALL verify back-to-back frames: two frames of 1,1,1,1 -> each yields 11,01,10,10,01,11 with no sr carry-over.
REQ-035 SHALL verify FRAME_LEN=1, din=1 -> dout 11,10,11, then FSM returns to IDLE.
